// File: rtl/sprite_cmd_dispatcher.sv
// sprite_cmd_dispatcher: buffers CPU sprite commands in a FIFO and forwards
// them to the display modules, stamping each word with the back-buffer bit.
// A COMMIT word waits for vblank, then a flip command is broadcast to every
// component ID and the front/back buffers swap.
//
// Ports:
//   clk              system clock
//   reset            asynchronous reset, active-low
//   cpu_write        push cpu_writedata this cycle
//   cpu_writedata    {comp,child,action,type,buf,data} command word
//   hcount, vcount   VGA counters used to find vblank start
//   cpu_full         FIFO full; pushes while high are dropped
//   overflow         sticky dropped-push flag, cleared only by reset
//   fifo_count       current FIFO occupancy
//   sprite_writedata registered command bus, 32'h0 = no-op
//   front_buf        buffer index currently displayed
module sprite_cmd_dispatcher #(
  parameter int         FIFO_DEPTH     = 16,
  parameter int         NUM_COMPONENTS = 12,
  parameter int         V_ACTIVE       = 480,
  parameter logic [5:0] COMMIT_ID      = 6'h3F
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_write,
  input  logic [31:0]                  cpu_writedata,
  input  logic [9:0]                   hcount,
  input  logic [9:0]                   vcount,
  output logic                         cpu_full,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [31:0]                  sprite_writedata,
  output logic                         front_buf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT =
    (AW+1)'(FIFO_DEPTH);
  localparam logic [5:0] LAST_IDX =
    6'(NUM_COMPONENTS);
  localparam logic [9:0] V_START =
    10'(V_ACTIVE);

  typedef enum logic [1:0] {
    DRAIN,
    WAIT_VBLANK,
    FLIP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   head;
  logic          push;
  logic          pop;
  logic          empty;
  logic          is_commit;

  logic          vb_lvl;
  logic          vb_q;
  logic          vb_start;

  logic [5:0]    idx;
  logic [5:0]    idx_nx;
  logic [31:0]   bus_nx;
  logic          front_nx;

  assign cpu_full   = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign push       = cpu_write && !cpu_full;
  assign fifo_count = count;
  assign head       = mem[rd_ptr];
  assign is_commit  = (head[31:26] == COMMIT_ID);

  // Level can sit high for many cycles; only
  // its rising edge starts a flip.
  assign vb_lvl   = (vcount == V_START) &&
                    (hcount == 10'd0);
  assign vb_start = vb_lvl && !vb_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cpu_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cpu_write && cpu_full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= DRAIN;
      idx              <= 6'd1;
      front_buf        <= 1'b0;
      sprite_writedata <= '0;
      vb_q             <= 1'b0;
    end else begin
      state            <= state_nx;
      idx              <= idx_nx;
      front_buf        <= front_nx;
      sprite_writedata <= bus_nx;
      vb_q             <= vb_lvl;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    bus_nx   = '0;
    front_nx = front_buf;
    pop      = 1'b0;
    unique case (1'b1)
      (state == DRAIN): begin
        if (!empty) begin
          pop = 1'b1;
          if (is_commit) begin
            state_nx = WAIT_VBLANK;
          end else begin
            // Replace bit 13 with the back buffer.
            bus_nx = (head & ~32'h0000_2000) |
                     {18'd0, ~front_buf, 13'd0};
          end
        end
      end
      (state == WAIT_VBLANK): begin
        if (vb_start) begin
          state_nx = FLIP;
          idx_nx   = 6'd1;
        end
      end
      (state == FLIP): begin
        bus_nx = {idx, 5'd0, 4'hF, 3'd0,
                  ~front_buf, 13'd0};
        if (idx == LAST_IDX) begin
          front_nx = ~front_buf;
          idx_nx   = 6'd1;
          state_nx = DRAIN;
        end else begin
          idx_nx = idx + 6'd1;
        end
      end
      default: begin
        state_nx = DRAIN;
      end
    endcase
  end

endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// tb_sprite_cmd_dispatcher: directed and random stimulus
// against a queue-based model of the command dispatcher.
module tb_sprite_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        cpu_full;
  logic        overflow;
  logic [4:0]  fifo_count;
  logic [31:0] sprite_writedata;
  logic        front_buf;

  always #5 clk = ~clk;

  sprite_cmd_dispatcher dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_write        (cpu_write),
    .cpu_writedata    (cpu_writedata),
    .hcount           (hcount),
    .vcount           (vcount),
    .cpu_full         (cpu_full),
    .overflow         (overflow),
    .fifo_count       (fifo_count),
    .sprite_writedata (sprite_writedata),
    .front_buf        (front_buf)
  );

  // Model: pending commands, scheduled flip
  // words, and a "waiting for vblank" flag.
  logic [31:0] q[$];
  logic [31:0] flip_q[$];
  bit          waiting;
  bit          m_front;
  bit          m_ovf;
  logic [31:0] m_bus;
  bit          vb_prev;
  bit          m_lvl;
  bit          m_vbs;
  bit          m_full;
  logic [31:0] m_h;

  function automatic logic [31:0] flip_word(
    input int k, input bit b);
    return (32'(k) << 26) | (32'hF << 17) |
           (32'(b) << 13);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      flip_q.delete();
      waiting = 0;
      m_front = 0;
      m_ovf   = 0;
      m_bus   = '0;
      vb_prev = 0;
    end else begin
      m_lvl   = (vcount == 10'd480) && (hcount == 10'd0);
      m_vbs   = m_lvl && !vb_prev;
      vb_prev = m_lvl;
      m_full  = (q.size() == 16);
      m_bus   = '0;
      if (flip_q.size() > 0) begin
        m_bus = flip_q.pop_front();
        if (flip_q.size() == 0) m_front = ~m_front;
      end else if (waiting) begin
        if (m_vbs) begin
          for (int k = 1; k <= 12; k++)
            flip_q.push_back(flip_word(k, ~m_front));
          waiting = 0;
        end
      end else if (q.size() > 0) begin
        m_h = q.pop_front();
        if (m_h[31:26] == 6'h3F) begin
          waiting = 1;
        end else begin
          m_h[13] = ~m_front;
          m_bus   = m_h;
        end
      end
      if (cpu_write) begin
        if (m_full) m_ovf = 1;
        else q.push_back(cpu_writedata);
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;

  bit          le_bus, le_front, le_full;
  bit          le_ovf, le_cnt;
  logic [31:0] lv_bus;
  bit          lv_front, lv_full, lv_ovf;
  int          lv_cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("bus", sprite_writedata, m_bus);
      chk("front", 32'(front_buf), 32'(m_front));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("count", 32'(fifo_count), 32'(q.size()));
      chk("full", 32'(cpu_full),
          32'(q.size() == 16));
      if (le_bus)
        chk("lit_bus", sprite_writedata, lv_bus);
      if (le_front)
        chk("lit_front", 32'(front_buf), 32'(lv_front));
      if (le_full)
        chk("lit_full", 32'(cpu_full), 32'(lv_full));
      if (le_ovf)
        chk("lit_ovf", 32'(overflow), 32'(lv_ovf));
      if (le_cnt)
        chk("lit_count", 32'(fifo_count), 32'(lv_cnt));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    le_bus   = 0;
    le_front = 0;
    le_full  = 0;
    le_ovf   = 0;
    le_cnt   = 0;
  endtask

  task automatic e_bus(input logic [31:0] v);
    le_bus = 1; lv_bus = v;
  endtask
  task automatic e_front(input bit v);
    le_front = 1; lv_front = v;
  endtask
  task automatic e_full(input bit v);
    le_full = 1; lv_full = v;
  endtask
  task automatic e_ovf(input bit v);
    le_ovf = 1; lv_ovf = v;
  endtask
  task automatic e_cnt(input int v);
    le_cnt = 1; lv_cnt = v;
  endtask

  task automatic push(input logic [31:0] d);
    cpu_write     = 1'b1;
    cpu_writedata = d;
  endtask
  task automatic idle();
    cpu_write = 1'b0;
  endtask
  task automatic vb(input bit on);
    vcount = on ? 10'd480 : 10'd0;
    hcount = on ? 10'd0 : 10'd5;
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [31:0] d;
    d = $urandom;
    d[31:26] = 6'($urandom_range(1, 62));
    return d;
  endfunction

  initial begin
    reset = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    vb(0);
    chk_on = 1;
    step();
    step();
    e_bus(0); e_front(0); e_full(0);
    e_cnt(0); e_ovf(0);
    step();
    reset = 1'b1;
    e_bus(0); e_front(0); e_full(0);
    e_cnt(0); e_ovf(0);

    // single word, bit 13 restamped
    step(); push(32'h24028064);
    step(); idle(); e_bus(32'h2402A064);
    step(); e_bus(0);

    // commit then vblank flip
    step(); push(32'hFC000000);
    step(); idle(); e_bus(0);
    step(); e_bus(0);
    step(); vb(1); e_bus(0);
    for (int k = 1; k <= 12; k++) begin
      step();
      e_front(k == 12);
      if (k == 1) e_bus(32'h041E2000);
      if (k == 9) e_bus(32'h241E2000);
      if (k == 12) e_bus(32'h301E2000);
    end
    step(); vb(0); e_bus(0); e_front(1);

    // reset in the middle of a flip
    step(); push(32'hFC000000);
    step(); idle();
    step(); vb(1);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) e_bus(32'h101E0000);
    end
    step(); reset = 1'b0;
    e_bus(0); e_front(0); e_cnt(0);
    step(); vb(0);
    step(); reset = 1'b1; e_bus(0); e_cnt(0);

    // fill behind a commit, overflow, flip, drain
    step(); push(32'hFC000000);
    step(); push(32'h24028064);
    for (int i = 0; i < 16; i++) begin
      step(); push(rand_cmd());
      if (i == 13) begin e_cnt(15); e_full(0); end
      if (i == 14) begin e_cnt(16); e_full(1); end
      if (i == 15) begin e_cnt(16); e_ovf(1); end
    end
    step(); idle(); vb(1); e_ovf(1); e_bus(0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 12) begin
        e_bus(32'h301E2000); e_front(1);
      end
    end
    step(); vb(0); e_bus(32'h24028064);
    for (int i = 0; i < 20; i++) step();
    e_cnt(0); e_ovf(1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = ($urandom % 600 == 0) ? 1'b0 : 1'b1;
      cpu_write = ($urandom % 10) < 6;
      cpu_writedata = ($urandom % 12 == 0) ?
        {6'h3F, 26'($urandom)} : rand_cmd();
      if ($urandom % 16 == 0) begin
        vb(1);
      end else begin
        vcount = 10'($urandom);
        hcount = 10'($urandom);
      end
    end
    step(); idle(); reset = 1'b1; vb(0);
    step();
    step();
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
